// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects and enables, counts retired instructions and halts on illegal opcodes.
package multicycle_control_fsm_pkg;
  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_SLT     = 4'd5,
    ALU_SLTU    = 4'd6,
    ALU_SLL     = 4'd7,
    ALU_SRL     = 4'd8,
    ALU_SRA     = 4'd9,
    ALU_INVALID = 4'd15
  } alu_control_t;
endpackage

module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       instruction_type,
  input  alu_control_t     r_alu_op,
  input  alu_control_t     i_alu_op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_wr_en,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output alu_control_t     alu_control,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_L = 3'd2;
  localparam logic [2:0] TYPE_S = 3'd3;
  localparam logic [2:0] TYPE_B = 3'd4;
  localparam logic [2:0] TYPE_U = 3'd5;
  localparam logic [2:0] TYPE_J = 3'd6;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_EXEC_U   = 4'd9,
    S_JAL      = 4'd10,
    S_ALUWB    = 4'd11,
    S_BRANCH   = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire_s;

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state selection; retire_s marks the final cycle of each instruction
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instruction_type)
          TYPE_R:         state_d = (r_alu_op == ALU_INVALID) ? S_HALT : S_EXEC_R;
          TYPE_I:         state_d = (i_alu_op == ALU_INVALID) ? S_HALT : S_EXEC_I;
          TYPE_L, TYPE_S: state_d = S_MEMADR;
          TYPE_B:         state_d = S_BRANCH;
          TYPE_U:         state_d = S_EXEC_U;
          TYPE_J:         state_d = S_JAL;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        if (instruction_type == TYPE_L) state_d = S_MEMREAD;
        else if (instruction_type == TYPE_S) state_d = S_MEMWRITE;
        else state_d = S_HALT;
      end
      S_MEMREAD: state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWRITE: begin
        state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
        retire_s = mem_ready;
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Sticky flag follows entry into HALT; counter wraps naturally at 2^CNT_W
  always_comb begin
    illegal_d = illegal_q | (state_d == S_HALT);
    if (retire_s) retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          retired_d = retired_q;
  end

  // Datapath controls decoded from the current state
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_wr_en   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_wr_en = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = r_alu_op;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = i_alu_op;
      end
      S_EXEC_U: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = branch_taken;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign illegal_instr = illegal_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: per-instruction expectations come from the instruction-level timing rules;
// a negedge monitor accumulates control activity and compares on every retirement.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [2:0]       instruction_type;
  alu_control_t     r_alu_op, i_alu_op;
  logic             branch_taken, mem_ready;
  logic             pc_write, ir_write, reg_write, mem_wr_en, adr_src;
  logic [1:0]       alu_src_a, alu_src_b, result_src;
  alu_control_t     alu_control;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instruction_type(instruction_type),
    .r_alu_op(r_alu_op), .i_alu_op(i_alu_op), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_wr_en(mem_wr_en), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .illegal_instr(illegal_instr), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lat; int rw; int mw; int pw; int iw; int adr;
    int alu; int bsel; int rsrc; int ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: per-instruction activity, compared when retired advances
  int acc_lat, acc_rw, acc_mw, acc_pw, acc_iw, acc_adr, cap_alu, cap_b, cap_rs;
  logic [CNT_W-1:0] last_ret;
  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      acc_lat = 0; acc_rw = 0; acc_mw = 0; acc_pw = 0; acc_iw = 0; acc_adr = 0;
      cap_alu = int'(ALU_ADD); cap_b = 3; cap_rs = 3;
      if (!rst) last_ret = '0;
    end else begin
      if (retired != last_ret) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", int'(retired), int'(last_ret));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("latency", acc_lat, e.lat);
          check("reg_write_cycles", acc_rw, e.rw);
          check("mem_wr_en_cycles", acc_mw, e.mw);
          check("pc_write_cycles", acc_pw, e.pw);
          check("ir_write_cycles", acc_iw, e.iw);
          check("adr_src_cycles", acc_adr, e.adr);
          check("exec_alu_control", cap_alu, e.alu);
          check("exec_alu_src_b", cap_b, e.bsel);
          check("wb_result_src", cap_rs, e.rsrc);
          check("retired", int'(retired), e.ret);
        end
        last_ret = retired;
        acc_lat = 0; acc_rw = 0; acc_mw = 0; acc_pw = 0; acc_iw = 0; acc_adr = 0;
        cap_alu = int'(ALU_ADD); cap_b = 3; cap_rs = 3;
      end
      acc_lat++;
      acc_rw  += int'(reg_write);
      acc_mw  += int'(mem_wr_en);
      acc_pw  += int'(pc_write);
      acc_iw  += int'(ir_write);
      acc_adr += int'(adr_src);
      if (alu_src_a == 2'b10) begin
        cap_alu = int'(alu_control);
        cap_b   = int'(alu_src_b);
      end
      if (reg_write) cap_rs = int'(result_src);
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_enables", int'({pc_write, ir_write, reg_write, mem_wr_en, adr_src}), 0);
    check("rst_illegal", int'(illegal_instr), 0);
    check("rst_retired", int'(retired), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    n_ret = 0;
    #1;
    check("reset_state_enables", int'({pc_write, ir_write, reg_write, mem_wr_en}), 0);
    @(posedge clk);
    #1;
  endtask

  // Reference timing: fetch f+1, decode 1, then per-type phases; memory waits add m cycles
  task automatic run_instr(input int ty, input alu_control_t rop, input alu_control_t iop,
                           input bit bt, input int f, input int m);
    exp_t e;
    int   mem_start;
    e.lat = 0; e.rw = 0; e.mw = 0; e.pw = 1; e.iw = 1; e.adr = 0;
    e.alu = int'(ALU_ADD); e.bsel = 3; e.rsrc = 3;
    mem_start = -1;
    case (ty)
      0: begin e.lat = f + 4; e.rw = 1; e.alu = int'(rop); e.bsel = 0; e.rsrc = 0; end
      1: begin e.lat = f + 4; e.rw = 1; e.alu = int'(iop); e.bsel = 1; e.rsrc = 0; end
      2: begin e.lat = f + 5 + m; e.rw = 1; e.bsel = 1; e.rsrc = 1; e.adr = m + 1; mem_start = f + 3; end
      3: begin e.lat = f + 4 + m; e.mw = m + 1; e.bsel = 1; e.adr = m + 1; mem_start = f + 3; end
      4: begin e.lat = f + 3; e.pw = 1 + int'(bt); e.alu = int'(ALU_SUB); e.bsel = 0; end
      5: begin e.lat = f + 4; e.rw = 1; e.rsrc = 0; end
      default: begin e.lat = f + 4; e.rw = 1; e.rsrc = 0; e.pw = 2; end
    endcase
    n_ret++;
    e.ret = n_ret % (1 << CNT_W);
    sb_q.push_back(e);
    instruction_type = 3'(ty);
    r_alu_op         = rop;
    i_alu_op         = iop;
    branch_taken     = bt;
    for (int c = 0; c < e.lat; c++) begin
      if (c < f)                               mem_ready = 1'b0;
      else if (c == f)                         mem_ready = 1'b1;
      else if (mem_start >= 0 && c >= mem_start) mem_ready = (c == mem_start + m);
      else                                     mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 6 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic halt_test(input int ty, input alu_control_t rop, input alu_control_t iop);
    do_reset();
    instruction_type = 3'(ty);
    r_alu_op = rop;
    i_alu_op = iop;
    mem_ready = 1'b1;
    @(negedge clk);
    check("illegal_before_halt", int'(illegal_instr), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready        = 1'($urandom_range(0, 1));
      instruction_type = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("halt_enables", int'({pc_write, ir_write, reg_write, mem_wr_en, adr_src}), 0);
      check("halt_illegal", int'(illegal_instr), 1);
      @(posedge clk); #1;
    end
    check("halt_retired", int'(retired), 0);
  endtask

  initial begin
    rst = 1'b0; instruction_type = 3'd0; r_alu_op = ALU_ADD; i_alu_op = ALU_ADD;
    branch_taken = 1'b0; mem_ready = 1'b0;
    #1;
    do_reset();
    mon_en = 1'b1;
    run_instr(0, ALU_ADD, ALU_ADD, 1'b0, 0, 0);
    run_instr(2, ALU_ADD, ALU_ADD, 1'b0, 2, 1);
    run_instr(4, ALU_ADD, ALU_ADD, 1'b1, 0, 0);
    run_instr(4, ALU_ADD, ALU_ADD, 1'b0, 0, 0);
    run_instr(3, ALU_ADD, ALU_ADD, 1'b0, 0, 3);
    run_instr(6, ALU_ADD, ALU_ADD, 1'b0, 1, 0);
    run_instr(5, ALU_ADD, ALU_ADD, 1'b0, 0, 0);
    run_instr(1, ALU_XOR, ALU_SRA, 1'b0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      run_instr(int'($urandom_range(0, 6)),
                alu_control_t'(4'($urandom_range(0, 9))),
                alu_control_t'(4'($urandom_range(0, 9))),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    drain();
    mon_en = 1'b0;

    halt_test(7, ALU_ADD, ALU_ADD);
    halt_test(0, ALU_INVALID, ALU_ADD);
    halt_test(1, ALU_ADD, ALU_INVALID);

    // Asynchronous reset while a store is waiting on memory
    do_reset();
    instruction_type = 3'd3;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("memwrite_active", int'(mem_wr_en), 1);
    #2;
    rst = 1'b0;
    #1;
    check("memwrite_async_drop", int'(mem_wr_en), 0);
    check("memwrite_rst_retired", int'(retired), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    n_ret = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_instr(0, ALU_OR, ALU_ADD, 1'b0, 0, 0);
    drain();
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
